// File: rtl/axil_router.sv
// AXI4-Lite address router: one core master port fanned out to NSLV slave ports.
// Independent read and write engines, one outstanding transaction each; unmapped
// addresses complete locally with DECERR.
module axil_router #(
  parameter int unsigned         NSLV   = 2,
  parameter int unsigned         SLV_AW = 12,
  parameter logic [NSLV*32-1:0]  BASE   = {32'h0000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0]  MASK   = {32'hFFFF_FFF0, 32'hFFFF_F000}
) (
  input  logic                   clk,
  input  logic                   rstn,
  // core read address / data
  input  logic [31:0]            core_axi_araddr,
  input  logic                   core_axi_arvalid,
  input  logic [2:0]             core_axi_arprot,
  output logic                   core_axi_arready,
  output logic [31:0]            core_axi_rdata,
  output logic [1:0]             core_axi_rresp,
  output logic                   core_axi_rvalid,
  input  logic                   core_axi_rready,
  // core write address / data / response
  input  logic [31:0]            core_axi_awaddr,
  input  logic                   core_axi_awvalid,
  input  logic [2:0]             core_axi_awprot,
  output logic                   core_axi_awready,
  input  logic [31:0]            core_axi_wdata,
  input  logic [3:0]             core_axi_wstrb,
  input  logic                   core_axi_wvalid,
  output logic                   core_axi_wready,
  output logic [1:0]             core_axi_bresp,
  output logic                   core_axi_bvalid,
  input  logic                   core_axi_bready,
  // slave read ports
  output logic [NSLV*SLV_AW-1:0] slv_axi_araddr,
  output logic [NSLV*3-1:0]      slv_axi_arprot,
  output logic [NSLV-1:0]        slv_axi_arvalid,
  input  logic [NSLV-1:0]        slv_axi_arready,
  input  logic [NSLV*32-1:0]     slv_axi_rdata,
  input  logic [NSLV*2-1:0]      slv_axi_rresp,
  input  logic [NSLV-1:0]        slv_axi_rvalid,
  output logic [NSLV-1:0]        slv_axi_rready,
  // slave write ports
  output logic [NSLV*SLV_AW-1:0] slv_axi_awaddr,
  output logic [NSLV*3-1:0]      slv_axi_awprot,
  output logic [NSLV-1:0]        slv_axi_awvalid,
  input  logic [NSLV-1:0]        slv_axi_awready,
  output logic [NSLV*32-1:0]     slv_axi_wdata,
  output logic [NSLV*4-1:0]      slv_axi_wstrb,
  output logic [NSLV-1:0]        slv_axi_wvalid,
  input  logic [NSLV-1:0]        slv_axi_wready,
  input  logic [NSLV*2-1:0]      slv_axi_bresp,
  input  logic [NSLV-1:0]        slv_axi_bvalid,
  output logic [NSLV-1:0]        slv_axi_bready,
  // debug
  output logic [2:0]             reading_state,
  output logic [2:0]             writing_state
);

  localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_ADDR = 3'd1;
  localparam logic [2:0] R_DATA = 3'd2;
  localparam logic [2:0] R_RESP = 3'd3;

  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_FWD  = 3'd1;
  localparam logic [2:0] W_WAIT = 3'd2;
  localparam logic [2:0] W_RESP = 3'd3;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read engine state
  logic [2:0]        r_state_q, r_state_d;
  logic [SW-1:0]     r_sel_q, r_sel_d;
  logic              r_hit_q, r_hit_d;
  logic [SLV_AW-1:0] r_addr_q, r_addr_d;
  logic [2:0]        r_prot_q, r_prot_d;
  logic [31:0]       r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              ar_rdy_q, ar_rdy_d;

  // Write engine state
  logic [2:0]        w_state_q, w_state_d;
  logic [SW-1:0]     w_sel_q, w_sel_d;
  logic              w_hit_q, w_hit_d;
  logic [SLV_AW-1:0] w_addr_q, w_addr_d;
  logic [2:0]        w_prot_q, w_prot_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic [1:0]        w_resp_q, w_resp_d;
  logic              aw_done_q, aw_done_d;
  logic              wd_done_q, wd_done_d;
  logic              w_idle_q, w_idle_d;

  // Decode results and selected-slave inputs
  logic          ar_hit, aw_hit;
  logic [SW-1:0] ar_idx, aw_idx;
  logic          sel_arready, sel_rvalid, sel_awready, sel_wready, sel_bvalid;
  logic [31:0]   sel_rdata;
  logic [1:0]    sel_rresp, sel_bresp;
  logic          ar_fire, aw_fire;

  // Address decode: scan from the top down so the lowest matching index wins
  always_comb begin
    ar_hit = 1'b0;
    ar_idx = '0;
    aw_hit = 1'b0;
    aw_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((core_axi_araddr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
        ar_hit = 1'b1;
        ar_idx = SW'(i);
      end
      if ((core_axi_awaddr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
        aw_hit = 1'b1;
        aw_idx = SW'(i);
      end
    end
  end

  // Mux the latched target slave's response-side inputs
  always_comb begin
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rdata   = '0;
    sel_rresp   = '0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_sel_q == SW'(i)) begin
        sel_arready = slv_axi_arready[i];
        sel_rvalid  = slv_axi_rvalid[i];
        sel_rdata   = slv_axi_rdata[32*i +: 32];
        sel_rresp   = slv_axi_rresp[2*i +: 2];
      end
      if (w_sel_q == SW'(i)) begin
        sel_awready = slv_axi_awready[i];
        sel_wready  = slv_axi_wready[i];
        sel_bvalid  = slv_axi_bvalid[i];
        sel_bresp   = slv_axi_bresp[2*i +: 2];
      end
    end
  end

  // Read engine next state
  always_comb begin
    r_state_d = r_state_q;
    r_sel_d   = r_sel_q;
    r_hit_d   = r_hit_q;
    r_addr_d  = r_addr_q;
    r_prot_d  = r_prot_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    ar_fire   = ar_rdy_q && core_axi_arvalid;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_sel_d  = ar_idx;
          r_hit_d  = ar_hit;
          r_addr_d = core_axi_araddr[SLV_AW-1:0];
          r_prot_d = core_axi_arprot;
          if (ar_hit) begin
            r_state_d = R_ADDR;
          end else begin
            r_data_d  = '0;
            r_resp_d  = RESP_DECERR;
            r_state_d = R_RESP;
          end
        end
      end
      R_ADDR: begin
        if (sel_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (sel_rvalid) begin
          r_data_d  = sel_rdata;
          r_resp_d  = sel_rresp;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (core_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    // arready is registered so it reads 0 while reset is asserted
    ar_rdy_d = (r_state_d == R_IDLE);
  end

  // Read engine registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      r_sel_q   <= '0;
      r_hit_q   <= 1'b0;
      r_addr_q  <= '0;
      r_prot_q  <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      ar_rdy_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_sel_q   <= r_sel_d;
      r_hit_q   <= r_hit_d;
      r_addr_q  <= r_addr_d;
      r_prot_q  <= r_prot_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      ar_rdy_q  <= ar_rdy_d;
    end
  end

  // Write engine next state; AW and W are only ever accepted together
  always_comb begin
    w_state_d = w_state_q;
    w_sel_d   = w_sel_q;
    w_hit_d   = w_hit_q;
    w_addr_d  = w_addr_q;
    w_prot_d  = w_prot_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_resp_d  = w_resp_q;
    aw_done_d = aw_done_q;
    wd_done_d = wd_done_q;
    aw_fire   = w_idle_q && core_axi_awvalid && core_axi_wvalid;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          w_sel_d   = aw_idx;
          w_hit_d   = aw_hit;
          w_addr_d  = core_axi_awaddr[SLV_AW-1:0];
          w_prot_d  = core_axi_awprot;
          w_data_d  = core_axi_wdata;
          w_strb_d  = core_axi_wstrb;
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
          if (aw_hit) begin
            w_state_d = W_FWD;
          end else begin
            w_resp_d  = RESP_DECERR;
            w_state_d = W_RESP;
          end
        end
      end
      W_FWD: begin
        // Each channel retires on its own handshake; move on once both have
        aw_done_d = aw_done_q || sel_awready;
        wd_done_d = wd_done_q || sel_wready;
        if (aw_done_d && wd_done_d) begin
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (sel_bvalid) begin
          w_resp_d  = sel_bresp;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (core_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    w_idle_d = (w_state_d == W_IDLE);
  end

  // Write engine registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      w_sel_q   <= '0;
      w_hit_q   <= 1'b0;
      w_addr_q  <= '0;
      w_prot_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_resp_q  <= '0;
      aw_done_q <= 1'b0;
      wd_done_q <= 1'b0;
      w_idle_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_sel_q   <= w_sel_d;
      w_hit_q   <= w_hit_d;
      w_addr_q  <= w_addr_d;
      w_prot_q  <= w_prot_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_resp_q  <= w_resp_d;
      aw_done_q <= aw_done_d;
      wd_done_q <= wd_done_d;
      w_idle_q  <= w_idle_d;
    end
  end

  // Core-side outputs
  assign core_axi_arready = ar_rdy_q;
  assign core_axi_rvalid  = (r_state_q == R_RESP);
  assign core_axi_rdata   = r_data_q;
  assign core_axi_rresp   = r_resp_q;
  assign core_axi_awready = aw_fire;
  assign core_axi_wready  = aw_fire;
  assign core_axi_bvalid  = (w_state_q == W_RESP);
  assign core_axi_bresp   = w_resp_q;
  assign reading_state    = r_state_q;
  assign writing_state    = w_state_q;

  // Slave-side outputs: only the latched target sees anything non-zero
  always_comb begin
    slv_axi_araddr  = '0;
    slv_axi_arprot  = '0;
    slv_axi_arvalid = '0;
    slv_axi_rready  = '0;
    slv_axi_awaddr  = '0;
    slv_axi_awprot  = '0;
    slv_axi_awvalid = '0;
    slv_axi_wdata   = '0;
    slv_axi_wstrb   = '0;
    slv_axi_wvalid  = '0;
    slv_axi_bready  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_hit_q && (r_sel_q == SW'(i))) begin
        slv_axi_araddr[SLV_AW*i +: SLV_AW] = r_addr_q;
        slv_axi_arprot[3*i +: 3]           = r_prot_q;
        slv_axi_arvalid[i]                 = (r_state_q == R_ADDR);
        slv_axi_rready[i]                  = (r_state_q == R_DATA);
      end
      if (w_hit_q && (w_sel_q == SW'(i))) begin
        slv_axi_awaddr[SLV_AW*i +: SLV_AW] = w_addr_q;
        slv_axi_awprot[3*i +: 3]           = w_prot_q;
        slv_axi_wdata[32*i +: 32]          = w_data_q;
        slv_axi_wstrb[4*i +: 4]            = w_strb_q;
        slv_axi_awvalid[i]                 = (w_state_q == W_FWD) && !aw_done_q;
        slv_axi_wvalid[i]                  = (w_state_q == W_FWD) && !wd_done_q;
        slv_axi_bready[i]                  = (w_state_q == W_WAIT);
      end
    end
  end

endmodule

// File: tb/tb_axil_router.sv
// Directed bench for axil_router. The default map leaves slave1 entirely shadowed
// by slave0, so the bench uses an overlapping map where slave0 (0x10..0x1F) sits
// inside slave1 (0x00..0xFF): 0x10/0x18 exercise priority, 0x04/0x20 reach slave1.
module tb_axil_router;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]     core_araddr, core_awaddr, core_wdata, core_rdata;
  logic [2:0]      core_arprot, core_awprot;
  logic [3:0]      core_wstrb;
  logic            core_arvalid, core_arready, core_rvalid, core_rready;
  logic            core_awvalid, core_awready, core_wvalid, core_wready;
  logic            core_bvalid, core_bready;
  logic [1:0]      core_rresp, core_bresp;
  logic [N*AW-1:0] slv_araddr, slv_awaddr;
  logic [N*3-1:0]  slv_arprot, slv_awprot;
  logic [N-1:0]    slv_arvalid, slv_arready, slv_rvalid, slv_rready;
  logic [N-1:0]    slv_awvalid, slv_awready, slv_wvalid, slv_wready, slv_bvalid, slv_bready;
  logic [N*32-1:0] slv_rdata, slv_wdata;
  logic [N*2-1:0]  slv_rresp, slv_bresp;
  logic [N*4-1:0]  slv_wstrb;
  logic [2:0]      reading_state, writing_state;

  int n_tests = 0;
  int n_fail  = 0;

  axil_router #(
    .NSLV  (N),
    .SLV_AW(AW),
    .BASE  ({32'h0000_0000, 32'h0000_0010}),
    .MASK  ({32'hFFFF_FF00, 32'hFFFF_FFF0})
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .core_axi_araddr  (core_araddr),
    .core_axi_arvalid (core_arvalid),
    .core_axi_arprot  (core_arprot),
    .core_axi_arready (core_arready),
    .core_axi_rdata   (core_rdata),
    .core_axi_rresp   (core_rresp),
    .core_axi_rvalid  (core_rvalid),
    .core_axi_rready  (core_rready),
    .core_axi_awaddr  (core_awaddr),
    .core_axi_awvalid (core_awvalid),
    .core_axi_awprot  (core_awprot),
    .core_axi_awready (core_awready),
    .core_axi_wdata   (core_wdata),
    .core_axi_wstrb   (core_wstrb),
    .core_axi_wvalid  (core_wvalid),
    .core_axi_wready  (core_wready),
    .core_axi_bresp   (core_bresp),
    .core_axi_bvalid  (core_bvalid),
    .core_axi_bready  (core_bready),
    .slv_axi_araddr   (slv_araddr),
    .slv_axi_arprot   (slv_arprot),
    .slv_axi_arvalid  (slv_arvalid),
    .slv_axi_arready  (slv_arready),
    .slv_axi_rdata    (slv_rdata),
    .slv_axi_rresp    (slv_rresp),
    .slv_axi_rvalid   (slv_rvalid),
    .slv_axi_rready   (slv_rready),
    .slv_axi_awaddr   (slv_awaddr),
    .slv_axi_awprot   (slv_awprot),
    .slv_axi_awvalid  (slv_awvalid),
    .slv_axi_awready  (slv_awready),
    .slv_axi_wdata    (slv_wdata),
    .slv_axi_wstrb    (slv_wstrb),
    .slv_axi_wvalid   (slv_wvalid),
    .slv_axi_wready   (slv_wready),
    .slv_axi_bresp    (slv_bresp),
    .slv_axi_bvalid   (slv_bvalid),
    .slv_axi_bready   (slv_bready),
    .reading_state    (reading_state),
    .writing_state    (writing_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    core_araddr = '0; core_arprot = '0; core_arvalid = 1'b0; core_rready = 1'b0;
    core_awaddr = '0; core_awprot = '0; core_awvalid = 1'b0;
    core_wdata = '0; core_wstrb = '0; core_wvalid = 1'b0; core_bready = 1'b0;
    slv_arready = '0; slv_rdata = '0; slv_rresp = '0; slv_rvalid = '0;
    slv_awready = '0; slv_wready = '0; slv_bresp = '0; slv_bvalid = '0;

    // Reset state
    #12;
    chk("rst_arready", core_arready, 0);
    chk("rst_awready", core_awready, 0);
    chk("rst_rvalid", core_rvalid, 0);
    chk("rst_bvalid", core_bvalid, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_slv_arvalid", slv_arvalid, 0);
    chk("rst_states", {reading_state, writing_state}, 0);
    @(posedge clk); #2; rstn = 1'b1;
    tick(); #1;
    chk("idle_arready", core_arready, 1);
    chk("idle_awready_novalid", core_awready, 0);

    // Zero-wait read of 0x10 -> slave0 (wins over slave1), rvalid at cycle 3
    core_araddr = 32'h0000_0010; core_arprot = 3'b010; core_arvalid = 1'b1;
    slv_arready = 2'b01; #1;
    chk("rd_arready", core_arready, 1);
    tick(); core_arvalid = 1'b0; #1;
    chk("rd_state_addr", reading_state, 1);
    chk("rd_slv_arvalid", slv_arvalid, 2'b01);
    chk("rd_araddr0", slv_araddr[11:0], 12'h010);
    chk("rd_araddr1", slv_araddr[23:12], 12'h000);
    chk("rd_arprot0", slv_arprot[2:0], 3'b010);
    chk("rd_arready_busy", core_arready, 0);
    tick(); #1;
    chk("rd_state_data", reading_state, 2);
    chk("rd_slv_rready", slv_rready, 2'b01);
    chk("rd_slv_arvalid_drop", slv_arvalid, 2'b00);
    chk("rd_rvalid_c2", core_rvalid, 0);
    slv_rvalid = 2'b01; slv_rdata[31:0] = 32'hDEAD_BEEF; slv_rresp[1:0] = 2'b00;
    tick(); slv_rvalid = 2'b00; #1;
    chk("rd_rvalid_c3", core_rvalid, 1);
    chk("rd_rdata", core_rdata, 32'hDEAD_BEEF);
    chk("rd_rresp", core_rresp, 2'b00);
    core_rready = 1'b1;
    tick(); core_rready = 1'b0; #1;
    chk("rd_done_rvalid", core_rvalid, 0);
    chk("rd_done_state", reading_state, 0);
    slv_arready = 2'b00;

    // Write 0x04 -> slave1; awready lags wready by two cycles
    core_awaddr = 32'h0000_0004; core_awprot = 3'b000;
    core_wdata = 32'h1234_5678; core_wstrb = 4'b0001;
    core_awvalid = 1'b1; core_wvalid = 1'b0; #1;
    chk("aw_only_awready", core_awready, 0);
    chk("aw_only_wready", core_wready, 0);
    tick(); #1;
    chk("aw_only_state", writing_state, 0);
    core_awvalid = 1'b0; core_wvalid = 1'b1; #1;
    chk("w_only_wready", core_wready, 0);
    core_awvalid = 1'b1; slv_wready = 2'b10; #1;
    chk("wr_awready", core_awready, 1);
    chk("wr_wready", core_wready, 1);
    tick(); core_awvalid = 1'b0; core_wvalid = 1'b0; #1;
    chk("wr_state_fwd", writing_state, 1);
    chk("wr_slv_awvalid", slv_awvalid, 2'b10);
    chk("wr_slv_wvalid", slv_wvalid, 2'b10);
    chk("wr_awaddr1", slv_awaddr[23:12], 12'h004);
    chk("wr_awaddr0", slv_awaddr[11:0], 12'h000);
    chk("wr_wdata1", slv_wdata[63:32], 32'h1234_5678);
    chk("wr_wstrb1", slv_wstrb[7:4], 4'b0001);
    chk("wr_wdata0", slv_wdata[31:0], 32'h0);
    tick(); #1;
    chk("wr_w_dropped", slv_wvalid, 2'b00);
    chk("wr_aw_held", slv_awvalid, 2'b10);
    tick(); #1;
    chk("wr_aw_held2", slv_awvalid, 2'b10);
    chk("wr_still_fwd", writing_state, 1);
    slv_awready = 2'b10;
    tick(); slv_awready = 2'b00; slv_wready = 2'b00; #1;
    chk("wr_state_wait", writing_state, 2);
    chk("wr_aw_dropped", slv_awvalid, 2'b00);
    chk("wr_bready", slv_bready, 2'b10);
    chk("wr_bvalid_early", core_bvalid, 0);
    slv_bvalid = 2'b10; slv_bresp = 4'b1000;
    tick(); slv_bvalid = 2'b00; #1;
    chk("wr_bvalid", core_bvalid, 1);
    chk("wr_bresp_slverr", core_bresp, 2'b10);
    core_bready = 1'b1;
    tick(); core_bready = 1'b0; #1;
    chk("wr_done_state", writing_state, 0);
    chk("wr_done_bvalid", core_bvalid, 0);
    slv_bresp = '0;

    // Unmapped read: DECERR at cycle 1, no slave touched
    core_araddr = 32'h8000_0000; core_arvalid = 1'b1; #1;
    chk("dec_rd_arready", core_arready, 1);
    tick(); core_arvalid = 1'b0; #1;
    chk("dec_rd_rvalid", core_rvalid, 1);
    chk("dec_rd_rresp", core_rresp, 2'b11);
    chk("dec_rd_rdata", core_rdata, 32'h0);
    chk("dec_rd_slv_arvalid", slv_arvalid, 2'b00);
    core_rready = 1'b1;
    tick(); core_rready = 1'b0; #1;
    chk("dec_rd_idle", reading_state, 0);

    // Unmapped write: DECERR at cycle 1
    core_awaddr = 32'h8000_0000; core_awvalid = 1'b1; core_wvalid = 1'b1;
    tick(); core_awvalid = 1'b0; core_wvalid = 1'b0; #1;
    chk("dec_wr_bvalid", core_bvalid, 1);
    chk("dec_wr_bresp", core_bresp, 2'b11);
    chk("dec_wr_slv_awvalid", slv_awvalid, 2'b00);
    core_bready = 1'b1;
    tick(); core_bready = 1'b0; #1;
    chk("dec_wr_idle", writing_state, 0);

    // Concurrent read (0x18 -> slave0) and write (0x20 -> slave1), zero-wait slaves
    slv_arready = 2'b01; slv_awready = 2'b10; slv_wready = 2'b10;
    core_araddr = 32'h0000_0018; core_arprot = 3'b000; core_arvalid = 1'b1;
    core_awaddr = 32'h0000_0020; core_wdata = 32'hA5A5_5A5A; core_wstrb = 4'hF;
    core_awvalid = 1'b1; core_wvalid = 1'b1; #1;
    chk("cc_arready", core_arready, 1);
    chk("cc_awready", core_awready, 1);
    tick(); core_arvalid = 1'b0; core_awvalid = 1'b0; core_wvalid = 1'b0; #1;
    chk("cc_states_c1", {reading_state, writing_state}, {3'd1, 3'd1});
    chk("cc_slv_arvalid", slv_arvalid, 2'b01);
    chk("cc_araddr0", slv_araddr[11:0], 12'h018);
    chk("cc_slv_awvalid", slv_awvalid, 2'b10);
    chk("cc_awaddr1", slv_awaddr[23:12], 12'h020);
    tick(); #1;
    chk("cc_states_c2", {reading_state, writing_state}, {3'd2, 3'd2});
    slv_rvalid = 2'b01; slv_rdata[31:0] = 32'hCAFE_F00D; slv_rresp[1:0] = 2'b00;
    slv_bvalid = 2'b10; slv_bresp[3:2] = 2'b00;
    tick(); slv_rvalid = 2'b00; slv_bvalid = 2'b00; #1;
    chk("cc_rvalid", core_rvalid, 1);
    chk("cc_rdata", core_rdata, 32'hCAFE_F00D);
    chk("cc_bvalid", core_bvalid, 1);
    chk("cc_bresp", core_bresp, 2'b00);

    // rready held low 5 cycles: response stable, a new read is not accepted
    core_bready = 1'b1;
    core_araddr = 32'h8000_0000; core_arvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk("bp_rvalid", core_rvalid, 1);
      chk("bp_rdata", core_rdata, 32'hCAFE_F00D);
      chk("bp_rresp", core_rresp, 2'b00);
      chk("bp_arready", core_arready, 0);
    end
    core_bready = 1'b0;
    chk("bp_write_done", writing_state, 0);
    core_rready = 1'b1;
    tick(); #1;
    chk("bp_released_rvalid", core_rvalid, 0);
    chk("bp_released_arready", core_arready, 1);
    tick(); core_arvalid = 1'b0; #1;
    chk("bp_second_rvalid", core_rvalid, 1);
    chk("bp_second_rresp", core_rresp, 2'b11);
    tick(); core_rready = 1'b0; #1;
    chk("bp_second_idle", reading_state, 0);
    slv_awready = 2'b00; slv_wready = 2'b00;

    // Asynchronous reset while in R_DATA
    core_araddr = 32'h0000_0010; core_arvalid = 1'b1;
    tick(); core_arvalid = 1'b0;
    tick(); #1;
    chk("ar_rst_in_data", reading_state, 2);
    #2; rstn = 1'b0; #1;
    chk("ar_rst_state", reading_state, 0);
    chk("ar_rst_rready", slv_rready, 2'b00);
    chk("ar_rst_araddr", slv_araddr, 0);
    chk("ar_rst_arready", core_arready, 0);
    chk("ar_rst_rvalid", core_rvalid, 0);
    slv_arready = 2'b00;
    tick(); rstn = 1'b1;
    tick(); #1;
    chk("post_rst_arready", core_arready, 1);
    slv_arready = 2'b01;
    core_araddr = 32'h0000_0014; core_arvalid = 1'b1;
    tick(); core_arvalid = 1'b0;
    tick();
    slv_rvalid = 2'b01; slv_rdata[31:0] = 32'h0BAD_F00D; slv_rresp[1:0] = 2'b10;
    tick(); slv_rvalid = 2'b00; #1;
    chk("post_rst_rvalid", core_rvalid, 1);
    chk("post_rst_rdata", core_rdata, 32'h0BAD_F00D);
    chk("post_rst_rresp", core_rresp, 2'b10);
    core_rready = 1'b1;
    tick(); core_rready = 1'b0; #1;
    chk("post_rst_idle", reading_state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
